odd_parity_checker: RTL and testbench

Serial receive-side companion to the 4-bit odd parity generator. It accepts a bit-serial frame of DATA_W data bits followed by one parity bit, reassembles the data word and checks odd parity. Odd parity means the total count of ones over data plus parity must be odd. It presents the word with a one-cycle valid strobe and an error flag, and keeps a running error count. It sits between a serial link front end and the lab's display/LED logic.

---
 rtl/odd_parity_pkg.sv | 27 ++
 rtl/sat_counter.sv | 42 ++++
 rtl/odd_parity_checker.sv | 127 ++++++++++++
 tb/tb_odd_parity_checker.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/odd_parity_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : odd_parity_pkg
//  Description : Shared definitions for the odd parity generator/checker pair:
//                receiver FSM state encoding, default data width and an
//                odd-parity helper function.
//  Revision    : 1.0 - initial release
// ============================================================================
package odd_parity_pkg;

    // Default number of data bits per frame, shared with the generator
    localparam int unsigned c_data_w = 4;

    // Receiver state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Parity bit that makes the total ones count over word+parity odd
    function automatic logic odd_parity_bit(input logic [c_data_w-1:0] word);
        return ~(^word);
    endfunction

endpackage : odd_parity_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that increments on inc and sticks at its maximum
//                value instead of wrapping. Synchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    // Next count: step by one unless already pinned at the maximum
    always_comb begin
        w_count_d = r_count_q;
        if (inc && (r_count_q != c_cnt_max)) begin
            w_count_d = r_count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign count = r_count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/odd_parity_checker.sv
`default_nettype none
// ============================================================================
//  Module      : odd_parity_checker
//  Description : Bit-serial odd parity frame receiver. Reassembles DATA_W data
//                bits (first bit = MSB) followed by one parity bit, flags
//                frames whose total ones count is even, and strobes the word
//                out for one cycle.
//                Build option ODD_PARITY_ERRCNT_EN: when defined, a saturating
//                parity-error counter drives err_count; otherwise err_count
//                is tied to zero and no counter is built.
//  Revision    : 1.0 - initial release
// ============================================================================
module odd_parity_checker
    import odd_parity_pkg::*;
#(
    parameter int unsigned DATA_W = c_data_w,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              start,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic [CNT_W-1:0]  err_count
);

    // Index must be able to hold DATA_W itself (the "all data bits seen" value)
    localparam int unsigned       c_idx_w    = $clog2(DATA_W + 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_W);

    state_e              r_state_q,      w_state_d;
    logic [DATA_W-1:0]   r_shift_q,      w_shift_d;
    logic [c_idx_w-1:0]  r_idx_q,        w_idx_d;
    logic                r_par_q,        w_par_d;
    logic [DATA_W-1:0]   r_data_out_q,   w_data_out_d;
    logic                r_data_valid_q, w_data_valid_d;
    logic                r_parity_err_q, w_parity_err_d;

    // Next-state / datapath: a start-qualified bit always begins a new frame,
    // which also silently aborts any frame in progress
    always_comb begin
        w_state_d      = r_state_q;
        w_shift_d      = r_shift_q;
        w_idx_d        = r_idx_q;
        w_par_d        = r_par_q;
        w_data_out_d   = r_data_out_q;
        w_parity_err_d = r_parity_err_q;
        w_data_valid_d = 1'b0;

        if (bit_valid) begin
            if (start) begin
                w_shift_d = {{(DATA_W-1){1'b0}}, bit_in};
                w_par_d   = bit_in;
                w_idx_d   = c_idx_w'(1);
                w_state_d = ST_DATA;
            end else begin
                case (r_state_q)
                    ST_DATA: begin
                        w_shift_d = {r_shift_q[DATA_W-2:0], bit_in};
                        w_par_d   = r_par_q ^ bit_in;
                        w_idx_d   = r_idx_q + 1'b1;
                        if ((r_idx_q + 1'b1) == c_idx_last) begin
                            w_state_d = ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        w_data_out_d   = r_shift_q;
                        w_parity_err_d = ~(r_par_q ^ bit_in);
                        w_data_valid_d = 1'b1;
                        w_state_d      = ST_IDLE;
                    end
                    default: begin
                        // Idle: bits without start are not part of a frame
                    end
                endcase
            end
        end
    end

    // Frame state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_shift_q      <= '0;
            r_idx_q        <= '0;
            r_par_q        <= 1'b0;
            r_data_out_q   <= '0;
            r_data_valid_q <= 1'b0;
            r_parity_err_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_shift_q      <= w_shift_d;
            r_idx_q        <= w_idx_d;
            r_par_q        <= w_par_d;
            r_data_out_q   <= w_data_out_d;
            r_data_valid_q <= w_data_valid_d;
            r_parity_err_q <= w_parity_err_d;
        end
    end

    assign data_out   = r_data_out_q;
    assign data_valid = r_data_valid_q;
    assign parity_err = r_parity_err_q;

`ifdef ODD_PARITY_ERRCNT_EN
    // Count on the same edge that registers the failing frame, so err_count
    // already reflects it while data_valid is high
    logic w_err_inc;
    assign w_err_inc = w_data_valid_d & w_parity_err_d;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_err_inc),
        .count (err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule : odd_parity_checker
`default_nettype wire

// File: tb/tb_odd_parity_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_odd_parity_checker
//  Description : Self-checking bench for odd_parity_checker (DATA_W=4,
//                CNT_W=2). Directed frames push their expected result into a
//                scoreboard queue; a monitor pops and compares on data_valid.
//                Expected err_count follows ODD_PARITY_ERRCNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_odd_parity_checker;

    typedef struct packed {
        logic [3:0] data;
        logic       perr;
        logic [1:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       start = 1'b0;
    logic [3:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic [1:0] err_count;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   err_total = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    odd_parity_checker #(
        .DATA_W (4),
        .CNT_W  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .start      (start),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .err_count  (err_count)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one qualified bit for a single cycle (called at a negedge)
    task automatic send_bit(input logic b, input logic s);
        bit_in    = b;
        start     = s;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        start     = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Full frame, MSB first, with an expected result pushed before the parity bit
    task automatic send_frame(input logic [3:0] d, input logic p, input logic exp_err, input int gap);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send_bit(d[3-i], i == 0);
            repeat (gap) @(negedge clk);
        end
`ifdef ODD_PARITY_ERRCNT_EN
        if (exp_err && err_total < 3) err_total++;
`endif
        e.data = d;
        e.perr = exp_err;
        e.cnt  = 2'(err_total);
        exp_q.push_back(e);
        send_bit(p, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"},   {4'h0, data_out},   8'h00);
        check({tag, "_data_valid"}, {7'h0, data_valid}, 8'h00);
        check({tag, "_parity_err"}, {7'h0, parity_err}, 8'h00);
        check({tag, "_err_count"},  {6'h0, err_count},  8'h00);
    endtask

    // Monitor: compare each strobe against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && data_valid) begin
                check("strobe_single_cycle", {7'h0, prev_valid}, 8'h00);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got data_out=%0h with no frame pending at %0t", data_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out",   {4'h0, data_out},   {4'h0, e.data});
                    check("parity_err", {7'h0, parity_err}, {7'h0, e.perr});
                    check("err_count",  {6'h0, err_count},  {6'h0, e.cnt});
                end
            end
            prev_valid = data_valid;
        end
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got still running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Stray bit without start in idle must be dropped
        send_bit(1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // Good frames
        send_frame(4'b0000, 1'b1, 1'b0, 0);
        send_frame(4'b1011, 1'b0, 1'b0, 0);
        // Bad frame
        send_frame(4'b1100, 1'b0, 1'b1, 0);
        // Gaps of 3 idle cycles between every bit
        send_frame(4'b0101, 1'b1, 1'b0, 3);
        repeat (3) @(negedge clk);

        // Aborted partial frame followed by a fresh start-qualified frame
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_frame(4'b1000, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);

        // Reset after two data bits: nothing strobes, everything clears
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err_total = 0;
        check_reset_outputs("midframe_reset");
        send_frame(4'b0110, 1'b1, 1'b0, 0);
        repeat (2) @(negedge clk);

        // Five bad frames: counter saturates at 3 when enabled
        send_frame(4'b1111, 1'b0, 1'b1, 0);
        send_frame(4'b0001, 1'b1, 1'b1, 0);
        send_frame(4'b0011, 1'b0, 1'b1, 1);
        send_frame(4'b1110, 1'b1, 1'b1, 0);
        send_frame(4'b1000, 1'b1, 1'b1, 0);
        repeat (4) @(negedge clk);

        check("pending_frames", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_odd_parity_checker
`default_nettype wire
